// File: rtl/trigger_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// trigger_seq_pkg
// Shared definitions for the trigger sequencer:
//   - 2-bit state encoding for the sequencing FSM
//   - width helper for the repeat counter (must hold 0..ACCEL_STEPS)
// -----------------------------------------------------------------------------
package trigger_seq_pkg;

    localparam logic [1:0] ST_READY    = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_REFRESH  = 2'd2;
    localparam logic [1:0] ST_DEBOUNCE = 2'd3;

    typedef enum logic [1:0] {
        READY    = ST_READY,
        SETTLE   = ST_SETTLE,
        REFRESH  = ST_REFRESH,
        DEBOUNCE = ST_DEBOUNCE
    } state_t;

    // Width needed for a counter saturating at accel_steps (at least 1 bit).
    function automatic int rep_cnt_width(input int accel_steps);
        return (accel_steps < 1) ? 1 : $clog2(accel_steps + 1);
    endfunction

endpackage

// File: rtl/trigger_sequencer_repeat_timer.sv
// -----------------------------------------------------------------------------
// repeat_timer
// Tracks how long the channels of the current inc_mask have been held and how
// many auto-repeats have occurred, and flags when the next repeat is due.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   trigger         raw trigger inputs
//   inc_mask        channels responsible for the last increment
//   launch_edge     an increment caused by a fresh edge is launched this cycle
//   launch_repeat   an increment caused by auto-repeat is launched this cycle
//   repeat_due      hold time has reached the current repeat threshold
// -----------------------------------------------------------------------------
import trigger_seq_pkg::*;

module repeat_timer #(
    parameter int CHANNELS     = 6,
    parameter int CNT_WIDTH    = 20,
    parameter int REPEAT_DELAY = 333333,
    parameter int REPEAT_FAST  = 100000,
    parameter int ACCEL_STEPS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [CHANNELS-1:0] inc_mask,
    input  logic                launch_edge,
    input  logic                launch_repeat,
    output logic                repeat_due
);

    localparam int RW = rep_cnt_width(ACCEL_STEPS);
    localparam logic [RW-1:0]        REP_MAX  = RW'(ACCEL_STEPS);
    localparam logic [CNT_WIDTH-1:0] DELAY_M1 = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] FAST_M1  = CNT_WIDTH'(REPEAT_FAST - 1);

    logic [CNT_WIDTH-1:0] r_hold_timer;
    logic [RW-1:0]        r_rep_cnt;
    logic [CNT_WIDTH-1:0] w_threshold_m1;
    logic                 w_mask_held;

    assign w_mask_held    = |(trigger & inc_mask);
    // Slow repeats until ACCEL_STEPS repeats have happened (never, if 0).
    assign w_threshold_m1 = (r_rep_cnt < REP_MAX) ? DELAY_M1 : FAST_M1;
    // Launching at threshold-1 puts consecutive inc_clk exactly threshold apart.
    assign repeat_due     = (r_hold_timer >= w_threshold_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_timer <= '0;
            r_rep_cnt    <= '0;
        end else if (launch_edge) begin
            r_hold_timer <= '0;
            r_rep_cnt    <= '0;
        end else if (launch_repeat) begin
            r_hold_timer <= '0;
            r_rep_cnt    <= (r_rep_cnt == REP_MAX) ? r_rep_cnt : r_rep_cnt + 1'b1;
        end else if (!w_mask_held) begin
            r_hold_timer <= '0;
            r_rep_cnt    <= '0;
        end else if (r_hold_timer != '1) begin
            r_hold_timer <= r_hold_timer + 1'b1;
        end
    end

endmodule

// File: rtl/trigger_sequencer.sv
// -----------------------------------------------------------------------------
// trigger_sequencer
// Multi-channel trigger front end: edge detect, auto-repeat with acceleration,
// then a fixed settle time before a refresh pulse and a debounce lockout.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   trigger      synchronised active-high trigger inputs
//   repeat_en    allow auto-repeat launches
//   inc_clk      one-cycle increment pulse
//   inc_mask     channels behind the latest inc_clk (held until the next one)
//   ref_clk      one-cycle refresh pulse, SETTLE_CYCLES after inc_clk
//   busy         high whenever the sequencer is not READY
// -----------------------------------------------------------------------------
import trigger_seq_pkg::*;

module trigger_sequencer #(
    parameter int CHANNELS        = 6,
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SETTLE_CYCLES   = 10,
    parameter int REPEAT_DELAY    = 333333,
    parameter int REPEAT_FAST     = 100000,
    parameter int ACCEL_STEPS     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    input  logic                repeat_en,
    output logic                inc_clk,
    output logic [CHANNELS-1:0] inc_mask,
    output logic                ref_clk,
    output logic                busy
);

    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    // DEBOUNCE exits when the counter reaches DEBOUNCE_CYCLES, so together with
    // the REFRESH cycle the first READY cycle is N+SETTLE+2+DEBOUNCE.
    localparam logic [CNT_WIDTH-1:0] DEB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES);

    state_t               r_state, w_state_next;
    logic [CHANNELS-1:0]  r_prev, w_prev_next;
    logic [CHANNELS-1:0]  r_inc_mask, w_inc_mask_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                 r_inc_clk, w_inc_clk_next;
    logic                 r_ref_clk, w_ref_clk_next;
    logic                 r_busy;
    logic [CHANNELS-1:0]  w_rise, w_held;
    logic                 w_launch_edge, w_launch_repeat, w_repeat_due;

    // prev only updates in READY, so edges seen while busy surface on the
    // first READY cycle instead of being lost.
    assign w_rise = trigger & ~r_prev;
    assign w_held = trigger & r_prev;

    repeat_timer #(
        .CHANNELS     (CHANNELS),
        .CNT_WIDTH    (CNT_WIDTH),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_FAST  (REPEAT_FAST),
        .ACCEL_STEPS  (ACCEL_STEPS)
    ) u_repeat_timer (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .inc_mask      (r_inc_mask),
        .launch_edge   (w_launch_edge),
        .launch_repeat (w_launch_repeat),
        .repeat_due    (w_repeat_due)
    );

    always_comb begin
        w_state_next    = r_state;
        w_prev_next     = r_prev;
        w_inc_mask_next = r_inc_mask;
        w_cnt_next      = r_cnt;
        w_inc_clk_next  = 1'b0;
        w_ref_clk_next  = 1'b0;
        w_launch_edge   = 1'b0;
        w_launch_repeat = 1'b0;
        case (r_state)
            READY: begin
                w_prev_next = trigger;
                // Fresh edges win over a due repeat; mask holds only new edges.
                if (w_rise != '0) begin
                    w_launch_edge   = 1'b1;
                    w_inc_clk_next  = 1'b1;
                    w_inc_mask_next = w_rise;
                    w_cnt_next      = '0;
                    w_state_next    = SETTLE;
                end else if (repeat_en && (w_held != '0) && w_repeat_due) begin
                    w_launch_repeat = 1'b1;
                    w_inc_clk_next  = 1'b1;
                    w_inc_mask_next = w_held;
                    w_cnt_next      = '0;
                    w_state_next    = SETTLE;
                end
            end
            SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_ref_clk_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = REFRESH;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            REFRESH: begin
                w_cnt_next   = '0;
                w_state_next = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (r_cnt == DEB_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = READY;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = READY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= READY;
            r_prev     <= '0;
            r_inc_mask <= '0;
            r_cnt      <= '0;
            r_inc_clk  <= 1'b0;
            r_ref_clk  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_prev     <= w_prev_next;
            r_inc_mask <= w_inc_mask_next;
            r_cnt      <= w_cnt_next;
            r_inc_clk  <= w_inc_clk_next;
            r_ref_clk  <= w_ref_clk_next;
            r_busy     <= (w_state_next != READY);
        end
    end

    assign inc_clk  = r_inc_clk;
    assign inc_mask = r_inc_mask;
    assign ref_clk  = r_ref_clk;
    assign busy     = r_busy;

    // The fast repeat must outlast one full settle/refresh/debounce pass.
    a_param_legal: assert property (@(posedge clk) disable iff (reset)
        REPEAT_FAST > SETTLE_CYCLES + DEBOUNCE_CYCLES + 2);

endmodule

// File: tb/tb_trigger_sequencer.sv
module tb_trigger_sequencer;

    localparam int CH = 4;
    localparam int CW = 20;
    localparam int D  = 20;
    localparam int S  = 3;
    localparam int RD = 100;
    localparam int RF = 40;
    localparam int A  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] trigger = '0;
    logic          repeat_en = 1'b0;
    logic          inc_clk;
    logic [CH-1:0] inc_mask;
    logic          ref_clk;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    trigger_sequencer #(
        .CHANNELS        (CH),
        .CNT_WIDTH       (CW),
        .DEBOUNCE_CYCLES (D),
        .SETTLE_CYCLES   (S),
        .REPEAT_DELAY    (RD),
        .REPEAT_FAST     (RF),
        .ACCEL_STEPS     (A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .repeat_en (repeat_en),
        .inc_clk   (inc_clk),
        .inc_mask  (inc_mask),
        .ref_clk   (ref_clk),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Timeline reference model: cycle numbers of the pending inc/ref pulses,
    // the first cycle the sequencer accepts input again, and the cycle from
    // which the current hold has been measured.
    int            cyc;
    int            m_ready;
    int            m_inc;
    int            m_ref;
    int            m_tstart;
    int            m_reps;
    logic [CH-1:0] m_prev;
    logic [CH-1:0] m_mask;
    logic [6:0]    exp_out;
    logic [6:0]    obs;

    task automatic model_reset();
        cyc      = 0;
        m_ready  = 0;
        m_inc    = -1000;
        m_ref    = -1000;
        m_tstart = 0;
        m_reps   = 0;
        m_prev   = '0;
        m_mask   = '0;
        exp_out  = '0;
    endtask

    // Decide what the sequencer does with the inputs present during cycle cyc.
    task automatic model_decide();
        logic [CH-1:0] rise, held, new_mask;
        int            thr, new_reps;
        bit            launched;
        launched = 1'b0;
        new_mask = '0;
        new_reps = 0;
        if (cyc >= m_ready) begin
            rise = trigger & ~m_prev;
            held = trigger & m_prev;
            thr  = (m_reps < A) ? RD : RF;
            if (rise != '0) begin
                launched = 1'b1;
                new_mask = rise;
                new_reps = 0;
            end else if (repeat_en && held != '0 && (cyc - m_tstart) >= thr - 1) begin
                launched = 1'b1;
                new_mask = held;
                new_reps = (m_reps + 1 > A) ? A : m_reps + 1;
            end
            m_prev = trigger;
        end
        if (launched) begin
            m_mask   = new_mask;
            m_reps   = new_reps;
            m_tstart = cyc + 1;
            m_inc    = cyc + 1;
            m_ref    = cyc + 1 + S;
            m_ready  = cyc + 1 + S + 2 + D;
        end else if ((trigger & m_mask) == '0) begin
            m_tstart = cyc + 1;
            m_reps   = 0;
        end
    endtask

    task automatic tick(input logic [CH-1:0] t, input logic r);
        trigger   = t;
        repeat_en = r;
        model_decide();
        @(posedge clk);
        #1;
        cyc++;
        exp_out = {(cyc == m_inc), (cyc == m_ref), (cyc < m_ready), m_mask};
        obs     = {inc_clk, ref_clk, busy, inc_mask};
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        trigger   = '0;
        repeat_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({inc_clk, ref_clk, busy, inc_mask} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", {inc_clk, ref_clk, busy, inc_mask}, 7'b0);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_edge();
        int inc_at, ref_at, idle_at;
        inc_at = -1; ref_at = -1; idle_at = -1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            tick((cyc >= 10 && cyc < 16) ? 4'b0010 : 4'b0000, 1'b0);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL single_edge cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            if (inc_clk && inc_at < 0) inc_at = cyc;
            if (ref_clk && ref_at < 0) ref_at = cyc;
            if (inc_at >= 0 && !busy && idle_at < 0) idle_at = cyc;
        end
        checks++;
        if (inc_at != 11 || ref_at != 14 || idle_at != 36) begin
            failures++;
            $display("FAIL single_edge_timing got inc=%0d ref=%0d idle=%0d exp 11 14 36", inc_at, ref_at, idle_at);
        end
        $display("test_single_edge inc=%0d ref=%0d idle=%0d", inc_at, ref_at, idle_at);
    endtask

    task automatic test_pending_edge();
        int first_inc, second_inc;
        logic [CH-1:0] second_mask, t;
        first_inc = -1; second_inc = -1; second_mask = '0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            t = (cyc < 2) ? 4'b0000 : (cyc < 12) ? 4'b0001 : 4'b0101;
            tick(t, 1'b0);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL pending_edge cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            if (inc_clk) begin
                if (first_inc < 0) first_inc = cyc;
                else if (second_inc < 0) begin
                    second_inc  = cyc;
                    second_mask = inc_mask;
                end
            end
        end
        checks++;
        if (second_mask !== 4'b0100 || second_inc - first_inc != S + 2 + D + 1) begin
            failures++;
            $display("FAIL pending_edge_second got mask=%b gap=%0d exp mask=0100 gap=%0d",
                     second_mask, second_inc - first_inc, S + 2 + D + 1);
        end
        $display("test_pending_edge first=%0d second=%0d mask=%b", first_inc, second_inc, second_mask);
    endtask

    task automatic test_repeat_accel();
        int incs[$];
        do_reset();
        for (int i = 0; i < 402; i++) begin
            tick((i < 2) ? 4'b0000 : 4'b1000, 1'b1);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL repeat_accel cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            if (inc_clk) incs.push_back(cyc);
        end
        checks++;
        if (incs.size() != 7) begin
            failures++;
            $display("FAIL repeat_accel_count got=%0d exp=7", incs.size());
        end
        for (int k = 1; k < incs.size(); k++) begin
            checks++;
            if (incs[k] - incs[k-1] != ((k <= 2) ? RD : RF)) begin
                failures++;
                $display("FAIL repeat_accel_gap k=%0d got=%0d exp=%0d", k, incs[k] - incs[k-1], (k <= 2) ? RD : RF);
            end
        end
        $display("test_repeat_accel incs=%0d", incs.size());
    endtask

    task automatic test_no_repeat();
        int n_inc, n_ref, first, second;
        n_inc = 0; n_ref = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick((i < 2) ? 4'b0000 : 4'b1000, 1'b0);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL no_repeat cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            n_inc += int'(inc_clk);
            n_ref += int'(ref_clk);
        end
        checks++;
        if (n_inc != 1 || n_ref != 1) begin
            failures++;
            $display("FAIL no_repeat_count got inc=%0d ref=%0d exp 1 1", n_inc, n_ref);
        end
        // Timer kept running: enabling repeat now fires on the next cycle.
        tick(4'b1000, 1'b1);
        checks++;
        if (inc_clk !== 1'b1 || inc_mask !== 4'b1000) begin
            failures++;
            $display("FAIL late_enable got inc=%b mask=%b exp inc=1 mask=1000", inc_clk, inc_mask);
        end
        first = -1; second = -1;
        for (int i = 0; i < 200; i++) begin
            tick((i >= 30 && i < 35) ? 4'b0000 : 4'b1000, 1'b1);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL re_press cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            if (inc_clk && i >= 35) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
        end
        checks++;
        if (first < 0 || second - first != RD) begin
            failures++;
            $display("FAIL re_press_gap got=%0d exp=%0d", second - first, RD);
        end
        $display("test_no_repeat re-press first=%0d second=%0d", first, second);
    endtask

    task automatic test_edge_priority();
        int thr, pressed_at, next_inc;
        pressed_at = -1; next_inc = -1;
        do_reset();
        for (int i = 0; i < 400 && next_inc < 0; i++) begin
            thr = (m_reps < A) ? RD : RF;
            if (pressed_at < 0 && i > 50 && cyc >= m_ready && (cyc - m_tstart) >= thr - 1) begin
                tick(4'b0011, 1'b1);
                pressed_at = cyc;
                checks++;
                if (inc_clk !== 1'b1 || inc_mask !== 4'b0010) begin
                    failures++;
                    $display("FAIL edge_priority got inc=%b mask=%b exp inc=1 mask=0010", inc_clk, inc_mask);
                end
            end else begin
                tick((i < 2) ? 4'b0000 : (pressed_at < 0) ? 4'b0001 : 4'b0011, 1'b1);
                if (pressed_at >= 0 && inc_clk) next_inc = cyc;
            end
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL edge_priority_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
        end
        checks++;
        if (pressed_at < 0 || next_inc - pressed_at != RD) begin
            failures++;
            $display("FAIL edge_priority_restart got gap=%0d exp=%0d", next_inc - pressed_at, RD);
        end
        $display("test_edge_priority pressed=%0d next=%0d", pressed_at, next_inc);
    endtask

    task automatic test_reset_mid();
        int ref_seen;
        ref_seen = 0;
        do_reset();
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({inc_clk, ref_clk, busy, inc_mask} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_abort got=%b exp=%b", {inc_clk, ref_clk, busy, inc_mask}, 7'b0);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            ref_seen += int'(ref_clk);
        end
        checks++;
        if (ref_seen != 0) begin
            failures++;
            $display("FAIL reset_mid_no_ref got=%0d exp=0", ref_seen);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            tick(4'b0010, 1'b0);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL reset_mid_seq cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            if (cyc == 1) begin
                checks++;
                if (inc_clk !== 1'b1 || inc_mask !== 4'b0010) begin
                    failures++;
                    $display("FAIL reset_mid_restart got inc=%b mask=%b exp inc=1 mask=0010", inc_clk, inc_mask);
                end
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [CH-1:0] t;
        logic          r;
        int            n_inc;
        t = '0; r = 1'b1; n_inc = 0;
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 59) == 0) t[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) r = ~r;
            tick(t, r);
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_out);
            end
            n_inc += int'(inc_clk);
        end
        $display("test_random incs=%0d", n_inc);
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_pending_edge();
        test_repeat_accel();
        test_no_repeat();
        test_edge_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
Multi-channel successor to the single-rate trigger counter. Debounces a vector of button/trigger inputs and emits a common increment pulse plus a mask of the responsible channels. Supports auto-repeat with acceleration (slow initial repeat, fast repeat after N repeats), with repeat gated at runtime. After every increment it emits a delayed refresh pulse for the display/output stage; it sits between the input pins and the digit counters/refresh logic.

Parameters:
CHANNELS, 6, number of trigger inputs
CNT_WIDTH, 20, width of the internal timers; must hold REPEAT_DELAY
DEBOUNCE_CYCLES, 10000, lockout cycles after each refresh
SETTLE_CYCLES, 10, cycles from inc_clk to ref_clk (carry ripple time)
REPEAT_DELAY, 333333, hold cycles per repeat while repeat count < ACCEL_STEPS
REPEAT_FAST, 100000, hold cycles per repeat once repeat count >= ACCEL_STEPS
ACCEL_STEPS, 4, repeats before switching to REPEAT_FAST (0 = always fast)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
trigger  in  CHANNELS  raw trigger inputs, already synchronised, active high
repeat_en  in  1  1 = auto-repeat allowed; 0 = edges only
inc_clk  out  1  one-cycle increment pulse
inc_mask  out  CHANNELS  channels causing the current inc_clk; held until next inc_clk
ref_clk  out  1  one-cycle refresh pulse
busy  out  1  high whenever state != READY

Behaviour:
- Reset (async, active-high): state=READY, inc_clk=0, ref_clk=0, inc_mask=0, prev=0, hold_timer=0, rep_cnt=0, settle/debounce counter=0, busy=0.
- States: READY, SETTLE, REFRESH, DEBOUNCE. All outputs are registered.
- READY: prev <= trigger every cycle; rise = trigger & ~prev.
  - rise != 0: inc_clk=1 next cycle, inc_mask<=rise, rep_cnt<=0, hold_timer<=0, go SETTLE.
  - rise == 0, repeat_en=1, prev&trigger != 0, hold_timer >= threshold-1: inc_clk=1, inc_mask<=prev&trigger, rep_cnt<=sat_inc(rep_cnt), hold_timer<=0, go SETTLE.
  - threshold = REPEAT_DELAY if rep_cnt < ACCEL_STEPS, else REPEAT_FAST.
- Edge priority: a fresh edge on any channel beats a repeat in the same cycle, and the mask contains only the new edges.
- Edges arriving outside READY are not lost. prev is frozen outside READY, so a channel that rose meanwhile and is still high yields rise on the first READY cycle.
- hold_timer:
  - Counts +1 every cycle, in all states, while trigger & inc_mask != 0.
  - Clears to 0, and rep_cnt clears to 0, on the cycle all inc_mask channels are low.
  - Saturates at all-ones and never wraps.
  - Net effect: repeat period equals threshold cycles, measured inc_clk to inc_clk.
- Legal parameters: REPEAT_FAST > SETTLE_CYCLES + DEBOUNCE_CYCLES + 2. Check with a simulation-time assertion.
- repeat_en=0: hold_timer still runs; only the repeat launch is suppressed. Raising repeat_en with timer >= threshold-1 repeats on the next READY cycle.
- SETTLE: entered in the cycle inc_clk is high (cycle N). Counts SETTLE_CYCLES; ref_clk is high in cycle N+SETTLE_CYCLES, and the state becomes REFRESH that cycle.
- REFRESH: one cycle, counter<=0, then DEBOUNCE.
- DEBOUNCE: counts DEBOUNCE_CYCLES cycles, then READY. The first READY cycle is N+SETTLE_CYCLES+2+DEBOUNCE_CYCLES.
- inc_clk and ref_clk are never high in the same cycle.
- rep_cnt saturates at ACCEL_STEPS.
- Reset mid-operation aborts immediately to the reset values; no ref_clk is owed.

Decomposition:
- Package trigger_seq_pkg: state encoding (2-bit localparams READY/SETTLE/REFRESH/DEBOUNCE), and a width helper for the rep_cnt width, clog2(ACCEL_STEPS+1).
- One sub-module, repeat_timer: hold_timer, rep_cnt, threshold select and the repeat_due output. The FSM, edge detect and settle/debounce counter stay in the top level.

Test Plan:
(params CHANNELS=4, DEBOUNCE_CYCLES=20, SETTLE_CYCLES=3, REPEAT_DELAY=100, REPEAT_FAST=40, ACCEL_STEPS=2)
- Reset, then trigger=4'b0010 at cycle 10 -> inc_clk at 11, inc_mask=0010, ref_clk at 14, busy low again at 36.
- trigger goes 0001 then 0101 in the same READY window (different cycles, second during DEBOUNCE) -> second inc_clk on the first READY cycle with inc_mask=0100.
- Hold 1000 with repeat_en=1 for 400 cycles -> inc_clk at t0, t0+100, t0+200, t0+240, t0+280, ...; each followed by ref_clk 3 cycles later.
- Same hold with repeat_en=0 -> exactly one inc_clk and one ref_clk. Release and re-press -> new inc_clk, and rep_cnt restarts (the next repeat comes at +100).
- Hold 0001 and press 0010 in the same cycle a repeat is due -> inc_mask=0010 only, and hold_timer restarts.
- Assert reset during SETTLE -> ref_clk never pulses, all outputs 0. After release, holding trigger high yields inc_clk on the second cycle.
